prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/sync_ff.sv | 23 ++
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader shared types.
// Opcodes carried in the top two bits of a command byte, plus FSM states.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_RUN  = 2'b10,
    OP_HALT = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_CMD  = 2'b00,
    ST_LEN  = 2'b01,
    ST_DATA = 2'b10,
    ST_CSUM = 2'b11
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for an asynchronous level input.
// The chain holds its contents while ena is low.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the async level through the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else if (ena) ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/prog_loader.sv
// Host byte loader: 4-phase byte handshake feeding a
// CMD/LEN/DATA/CSUM command FSM that writes program memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic vs;
  logic take;
  opcode_e op;

  state_e            state, state_n;
  logic [ADDR_W-1:0] cur, cur_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic [DATA_W-1:0] csum, csum_n;
  logic              ack_n, we_n, run_n, busy_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (host_valid),
    .q     (vs)
  );

  assign take = vs & ~host_ack;
  assign op   = opcode_e'(host_data[DATA_W-1 -: 2]);

  // next-state: handshake, command decode, payload handling
  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    csum_n  = csum;
    ack_n   = host_ack;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    run_n   = cpu_run;
    busy_n  = busy;
    err_n   = err;
    if (ena) begin
      if (host_ack && !vs) ack_n = 1'b0;
      if (take) begin
        ack_n = 1'b1;
        unique case (state)
          ST_CMD: begin
            unique case (op)
              OP_NOP: ;
              OP_LOAD: begin
                cur_n   = host_data[ADDR_W-1:0];
                csum_n  = '0;
                run_n   = 1'b0;
                busy_n  = 1'b1;
                err_n   = 1'b0;
                state_n = ST_LEN;
              end
              OP_RUN:  run_n = 1'b1;
              OP_HALT: run_n = 1'b0;
            endcase
          end
          ST_LEN: begin
            if (host_data[ADDR_W-1:0] == '0) cnt_n = CNT_FULL;
            else cnt_n = {1'b0, host_data[ADDR_W-1:0]};
            state_n = ST_DATA;
          end
          ST_DATA: begin
            we_n    = 1'b1;
            addr_n  = cur;
            wdata_n = host_data;
            cur_n   = cur + 1'b1;
            csum_n  = csum ^ host_data;
            cnt_n   = cnt - CNT_ONE;
            if (cnt == CNT_ONE) state_n = ST_CSUM;
          end
          ST_CSUM: begin
            if (host_data != csum) err_n = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_CMD;
          end
        endcase
      end
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CMD;
      cur       <= '0;
      cnt       <= '0;
      csum      <= '0;
      host_ack  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      cnt       <= cnt_n;
      csum      <= csum_n;
      host_ack  <= ack_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      cpu_run   <= run_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader.
// Drives host bytes over the 4-phase handshake and checks writes/flags.
module tb_prog_loader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic [DW-1:0] host_data = '0;
  logic          host_valid = 1'b0;
  logic          host_ack;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_run;
  logic          busy;
  logic          err;

  int nvec = 0;
  int nmis = 0;
  int lat;
  logic prev_we = 1'b0;
  logic [11:0] wq[$];
  logic [11:0] ew[$];
  logic [31:0] snap;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ack   (host_ack),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, host_ack, mem_we, mem_addr, mem_wdata,
            cpu_run, busy, err};
  endfunction

  // log every write pulse; a pulse must last exactly one cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      chk("we_pulse", {31'd0, prev_we}, 32'd0);
    end
    prev_we <= mem_we;
  end

  task automatic send(input logic [7:0] b);
    int n;
    host_data  = b;
    host_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ack && n < 12);
    lat = n;
    chk("ack_hi", {31'd0, host_ack}, 32'd1);
    host_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (host_ack && n < 12);
    chk("ack_lo", {31'd0, host_ack}, 32'd0);
  endtask

  task automatic cmp_writes();
    chk("nwr", wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++)
      chk($sformatf("wr%0d", i), {20'd0, wq[i]}, {20'd0, ew[i]});
    wq.delete();
    ew.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // plain handshake with a NOP byte
    snap = outs();
    host_data  = 8'h00;
    host_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!host_ack && lat < 12);
    chk("hs_rise_lat", {31'd0, lat <= SS + 2}, 32'd1);
    chk("hs_quiet1", outs() & ~32'h10000, snap);
    host_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (host_ack && lat < 12);
    chk("hs_fall_lat", {31'd0, lat <= SS + 2}, 32'd1);
    chk("hs_quiet2", outs(), snap);

    // normal load
    send(8'h43);
    chk("ld_busy", {31'd0, busy}, 32'd1);
    send(8'h03);
    send(8'hA1); send(8'hB2); send(8'hC3);
    chk("ld_busy_d", {31'd0, busy}, 32'd1);
    send(8'hD0);
    chk("ld_busy_end", {31'd0, busy}, 32'd0);
    chk("ld_err", {31'd0, err}, 32'd0);
    ew.push_back(12'h3A1); ew.push_back(12'h4B2); ew.push_back(12'h5C3);
    cmp_writes();
    chk("hold_addr", {28'd0, mem_addr}, 32'd5);
    chk("hold_data", {24'd0, mem_wdata}, 32'hC3);

    // address wrap
    send(8'h4E); send(8'h03);
    send(8'h01); send(8'h02); send(8'h04);
    send(8'h07);
    chk("wr_err", {31'd0, err}, 32'd0);
    ew.push_back(12'hE01); ew.push_back(12'hF02); ew.push_back(12'h004);
    cmp_writes();

    // bad checksum, then a LOAD clears err
    send(8'h43); send(8'h03);
    send(8'hA1); send(8'hB2); send(8'hC3);
    send(8'h00);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    send(8'h40);
    chk("clr_err", {31'd0, err}, 32'd0);
    send(8'h01); send(8'h55); send(8'h55);
    chk("clr_err2", {31'd0, err}, 32'd0);
    ew.push_back(12'h3A1); ew.push_back(12'h4B2); ew.push_back(12'h5C3);
    ew.push_back(12'h055);
    cmp_writes();

    // run control
    send(8'h80);
    chk("run_on", {31'd0, cpu_run}, 32'd1);
    send(8'h40);
    chk("run_off_ld", {31'd0, cpu_run}, 32'd0);
    send(8'h01); send(8'h66); send(8'h66);
    send(8'hC0);
    chk("run_halt", {31'd0, cpu_run}, 32'd0);
    ew.push_back(12'h066);
    cmp_writes();

    // ena low freezes the synchronizer and handshake
    host_data  = 8'h00;
    host_valid = 1'b1;
    ena = 1'b0;
    repeat (6) @(negedge clk);
    chk("ena_hold", {31'd0, host_ack}, 32'd0);
    ena = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!host_ack && lat < 12);
    chk("ena_resume", {31'd0, host_ack}, 32'd1);
    host_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (host_ack && lat < 12);

    // reset in the middle of DATA
    send(8'h40); send(8'h04);
    send(8'h11); send(8'h22);
    ew.push_back(12'h011); ew.push_back(12'h122);
    cmp_writes();
    #2 rst_n = 1'b0;
    #1 chk("mid_rst", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h80);
    chk("post_rst_run", {31'd0, cpu_run}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_nwr", wq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
